instruction_sequencer: RTL and testbench



---
 rtl/instruction_sequencer_if.sv | 30 +++
 rtl/instruction_sequencer.sv | 168 ++++++++++++++++
 tb/tb_instruction_sequencer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_if.sv
// instruction_sequencer_if
//   Bus between the instruction sequencer and its environment
//   (instruction memory, data RAM and datapath).
//   instruction  32  fetched instruction word (from instruction memory)
//   mem_ready     1  data RAM completed the current load/store
//   controlword  31  {Psel,DA,SA,SB,Fsel,regW,ramW,EN_MEM,EN_ALU,EN_B,EN_PC,Bsel,PCsel,SL}
//   K            64  datapath constant
//   state         2  00 FETCH, 01 EXEC, 10 MEM, 11 HALT
//   ir_load       1  IR captures instruction at the coming edge
//   halted        1  sequencer is in HALT
//   modport master: the sequencer side; modport slave: the environment side.
interface instruction_sequencer_if;
    logic [31:0] instruction;
    logic        mem_ready;
    logic [30:0] controlword;
    logic [63:0] K;
    logic [1:0]  state;
    logic        ir_load;
    logic        halted;

    modport master (
        input  instruction, mem_ready,
        output controlword, K, state, ir_load, halted
    );

    modport slave (
        output instruction, mem_ready,
        input  controlword, K, state, ir_load, halted
    );
endinterface

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Multicycle FETCH/EXEC/MEM controller for a LEGv8-style datapath.
//   Latches the instruction in FETCH, decodes it in EXEC and, for loads and
//   stores, waits in MEM for the data-RAM ready handshake. Outputs are
//   combinational from state, IR and mem_ready.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-low reset
//   bus    master modport of instruction_sequencer_if
// Optional feature:
//   SEQ_MEM_TIMEOUT_EN  when defined, a MEM stall of 15 cycles with mem_ready
//                       low sends the sequencer to HALT.
module instruction_sequencer (
    input  logic                      clock,
    input  logic                      reset,
    instruction_sequencer_if.master   bus
);

    typedef enum logic [1:0] {
        S_FETCH = 2'b00,
        S_EXEC  = 2'b01,
        S_MEM   = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [5:0]  OP_B    = 6'b000101;

    state_t      state_q, state_d;
    logic [31:0] ir;

    logic [1:0]  psel;
    logic [4:0]  da, sa, sb, fsel;
    logic        regw, ramw, en_mem, en_alu, en_b, en_pc, bsel, pcsel, sl;
    logic [63:0] k;
    logic        is_ld;

`ifdef SEQ_MEM_TIMEOUT_EN
    logic [3:0]  tcnt;

    // Cleared while leaving EXEC so it reads 0 on the first MEM cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (state_q == S_EXEC) begin
            tcnt <= '0;
        end else if (state_q == S_MEM && !bus.mem_ready) begin
            tcnt <= tcnt + 4'd1;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            ir      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                ir <= bus.instruction;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        psel    = '0;
        da      = '0;
        sa      = '0;
        sb      = '0;
        fsel    = '0;
        regw    = 1'b0;
        ramw    = 1'b0;
        en_mem  = 1'b0;
        en_alu  = 1'b0;
        en_b    = 1'b0;
        en_pc   = 1'b0;
        bsel    = 1'b0;
        pcsel   = 1'b0;
        sl      = 1'b0;
        k       = '0;
        is_ld   = (ir[31:21] == OP_LDUR);

        case (state_q)
            S_FETCH: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (ir[31:21])
                    OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                        da     = ir[4:0];
                        sa     = ir[9:5];
                        sb     = ir[20:16];
                        regw   = 1'b1;
                        en_alu = 1'b1;
                        psel   = 2'b01;
                        pcsel  = 1'b1;
                        case (ir[31:21])
                            OP_ADD:  fsel = 5'b01000;
                            OP_SUB:  fsel = 5'b01001;
                            OP_AND:  fsel = 5'b00000;
                            default: fsel = 5'b00100;
                        endcase
                        state_d = S_FETCH;
                    end
                    OP_LDUR, OP_STUR: begin
                        sa      = ir[9:5];
                        fsel    = 5'b01000;
                        bsel    = 1'b1;
                        k       = {55'd0, ir[20:12]};
                        state_d = S_MEM;
                    end
                    default: begin
                        if (ir[31:26] == OP_B) begin
                            k       = {{38{ir[25]}}, ir[25:0]};
                            psel    = 2'b10;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_HALT;
                        end
                    end
                endcase
            end
            S_MEM: begin
                sa   = ir[9:5];
                fsel = 5'b01000;
                bsel = 1'b1;
                k    = {55'd0, ir[20:12]};
                // Only LDUR or STUR can reach MEM, so "not load" means store.
                if (is_ld) begin
                    da     = ir[4:0];
                    en_mem = 1'b1;
                    regw   = bus.mem_ready;
                end else begin
                    sb     = ir[4:0];
                    ramw   = 1'b1;
                    en_b   = 1'b1;
                end
                psel = bus.mem_ready ? 2'b01 : 2'b00;
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end
`ifdef SEQ_MEM_TIMEOUT_EN
                // Counter would reach 15 at this edge: give up on the access.
                else if (tcnt == 4'd14) begin
                    state_d = S_HALT;
                end
`endif
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign bus.controlword = {psel, da, sa, sb, fsel, regw, ramw, en_mem,
                              en_alu, en_b, en_pc, bsel, pcsel, sl};
    assign bus.K           = k;
    assign bus.state       = state_q;
    assign bus.ir_load     = (state_q == S_FETCH);
    assign bus.halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_instruction_sequencer.sv
// tb_instruction_sequencer
//   Scoreboard bench: each instruction pushes its expected per-cycle outputs,
//   each clock cycle pops one entry and compares it against the DUT at the
//   falling edge.
module tb_instruction_sequencer;

    logic clock;
    logic reset;

    instruction_sequencer_if bus ();

    instruction_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [30:0] cw;
        logic [63:0] k;
        logic        il;
        logic        hl;
    } exp_t;

    exp_t scoreboard[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam logic [8:0] F_RTYPE = 9'b100100010; // regW EN_ALU PCsel
    localparam logic [8:0] F_ADDR  = 9'b000000100; // Bsel
    localparam logic [8:0] F_LDW   = 9'b001000100; // EN_MEM Bsel
    localparam logic [8:0] F_LDD   = 9'b101000100; // regW EN_MEM Bsel
    localparam logic [8:0] F_ST    = 9'b010010100; // ramW EN_B Bsel

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [30:0] cwf(input logic [1:0] psel, input logic [4:0] da,
                                        input logic [4:0] sa, input logic [4:0] sbr,
                                        input logic [4:0] fsel, input logic [8:0] flags);
        return {psel, da, sa, sbr, fsel, flags};
    endfunction

    function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rm,
                                          input logic [4:0] rn, input logic [4:0] rd);
        return {op, rm, 6'd0, rn, rd};
    endfunction

    task automatic push(input string tag, input logic [1:0] st, input logic [30:0] cw,
                        input logic [63:0] k, input logic il, input logic hl);
        exp_t e;
        e.tag = tag; e.st = st; e.cw = cw; e.k = k; e.il = il; e.hl = hl;
        scoreboard.push_back(e);
    endtask

    task automatic push_fetch(input string tag);
        push({tag, "_fetch"}, 2'b00, '0, '0, 1'b1, 1'b0);
    endtask

    // One clock cycle: drive inputs, compare at the falling edge, move past the rising edge.
    task automatic step(input logic [31:0] instr, input logic mr);
        exp_t e;
        bus.instruction = instr;
        bus.mem_ready   = mr;
        @(negedge clock);
        if (scoreboard.size() == 0) begin
            check_eq("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = scoreboard.pop_front();
            check_eq({e.tag, "_state"},   64'(bus.state),       64'(e.st));
            check_eq({e.tag, "_cw"},      64'(bus.controlword), 64'(e.cw));
            check_eq({e.tag, "_K"},       bus.K,                e.k);
            check_eq({e.tag, "_ir_load"}, 64'(bus.ir_load),     64'(e.il));
            check_eq({e.tag, "_halted"},  64'(bus.halted),      64'(e.hl));
        end
        @(posedge clock);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cw"},      64'(bus.controlword), 64'd0);
        check_eq({tag, "_K"},       bus.K,                64'd0);
        check_eq({tag, "_state"},   64'(bus.state),       64'd0);
        check_eq({tag, "_ir_load"}, 64'(bus.ir_load),     64'd1);
        check_eq({tag, "_halted"},  64'(bus.halted),      64'd0);
    endtask

    task automatic apply_reset(input string tag);
        reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    logic [10:0] rops  [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    logic [4:0]  rfsel [4] = '{5'b01000, 5'b01001, 5'b00000, 5'b00100};

    initial begin
        reset           = 1'b0;
        bus.instruction = '0;
        bus.mem_ready   = 1'b0;
        #2;
        check_reset_outputs("por");
        @(posedge clock);
        #1;
        reset = 1'b1;

        // ADD X3,X1,X2
        push_fetch("add");
        push("add_exec", 2'b01, cwf(2'b01, 5'd3, 5'd1, 5'd2, 5'b01000, F_RTYPE), '0, 1'b0, 1'b0);
        step(32'h8B020023, 1'b0);
        step(32'h8B020023, 1'b1);

        // All four R-type operations with distinct register fields
        for (int unsigned i = 0; i < 4; i++) begin
            logic [31:0] w;
            w = rtype(rops[i], 5'(i + 4), 5'(i + 10), 5'(i + 20));
            push_fetch("rtype");
            push("rtype_exec", 2'b01,
                 cwf(2'b01, 5'(i + 20), 5'(i + 10), 5'(i + 4), rfsel[i], F_RTYPE),
                 '0, 1'b0, 1'b0);
            step(w, 1'b0);
            step(w, 1'b0);
        end

        // LDUR X5,[X2,#8]: mem_ready high outside MEM must be ignored, two stall cycles
        push_fetch("ldur");
        push("ldur_exec",  2'b01, cwf(2'b00, 5'd0, 5'd2, 5'd0, 5'b01000, F_ADDR), 64'd8, 1'b0, 1'b0);
        push("ldur_wait1", 2'b10, cwf(2'b00, 5'd5, 5'd2, 5'd0, 5'b01000, F_LDW),  64'd8, 1'b0, 1'b0);
        push("ldur_wait2", 2'b10, cwf(2'b00, 5'd5, 5'd2, 5'd0, 5'b01000, F_LDW),  64'd8, 1'b0, 1'b0);
        push("ldur_done",  2'b10, cwf(2'b01, 5'd5, 5'd2, 5'd0, 5'b01000, F_LDD),  64'd8, 1'b0, 1'b0);
        step(32'hF8408045, 1'b1);
        step(32'hF8408045, 1'b1);
        step(32'hF8408045, 1'b0);
        step(32'hF8408045, 1'b0);
        step(32'hF8408045, 1'b1);

        // STUR X7,[X1,#0] with mem_ready on the first MEM cycle
        push_fetch("stur");
        push("stur_exec", 2'b01, cwf(2'b00, 5'd0, 5'd1, 5'd0, 5'b01000, F_ADDR), '0, 1'b0, 1'b0);
        push("stur_mem",  2'b10, cwf(2'b01, 5'd0, 5'd1, 5'd7, 5'b01000, F_ST),   '0, 1'b0, 1'b0);
        step(32'hF8000027, 1'b0);
        step(32'hF8000027, 1'b0);
        step(32'hF8000027, 1'b1);

        // B -1
        push_fetch("b");
        push("b_exec", 2'b01, {2'b10, 29'd0}, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
        step(32'h17FFFFFF, 1'b0);
        step(32'h17FFFFFF, 1'b0);

        // Returns to FETCH after the branch
        push_fetch("post_b");
        step(32'h8B020023, 1'b0);
        push("post_b_exec", 2'b01, cwf(2'b01, 5'd3, 5'd1, 5'd2, 5'b01000, F_RTYPE), '0, 1'b0, 1'b0);
        step(32'h8B020023, 1'b0);

        // Reset in the middle of a stalled STUR
        push_fetch("strst");
        push("strst_exec", 2'b01, cwf(2'b00, 5'd0, 5'd1, 5'd0, 5'b01000, F_ADDR), '0, 1'b0, 1'b0);
        step(32'hF8000027, 1'b0);
        step(32'hF8000027, 1'b0);
        bus.mem_ready = 1'b0;
        @(negedge clock);
        check_eq("strst_mem_state", 64'(bus.state), 64'd2);
        check_eq("strst_mem_ramw",  64'(bus.controlword[7]), 64'd1);
        #1;
        apply_reset("strst_reset");

        // Illegal opcode: HALT held for 20 cycles
        push_fetch("ill");
        push("ill_exec", 2'b01, '0, '0, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 20; i++) begin
            push("ill_halt", 2'b11, '0, '0, 1'b0, 1'b1);
        end
        for (int unsigned i = 0; i < 22; i++) begin
            step(32'h00000000, 1'b1);
        end
        apply_reset("halt_reset");

`ifdef SEQ_MEM_TIMEOUT_EN
        // LDUR with mem_ready stuck low: 15 MEM cycles without regW, then HALT
        push_fetch("tmo");
        push("tmo_exec", 2'b01, cwf(2'b00, 5'd0, 5'd2, 5'd0, 5'b01000, F_ADDR), 64'd8, 1'b0, 1'b0);
        for (int unsigned i = 0; i < 15; i++) begin
            push("tmo_wait", 2'b10, cwf(2'b00, 5'd5, 5'd2, 5'd0, 5'b01000, F_LDW), 64'd8, 1'b0, 1'b0);
        end
        push("tmo_halt", 2'b11, '0, '0, 1'b0, 1'b1);
        push("tmo_halt", 2'b11, '0, '0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < 19; i++) begin
            step(32'hF8408045, 1'b0);
        end
        apply_reset("tmo_reset");
`endif

        // Sanity run after the last reset
        push_fetch("final");
        push("final_exec", 2'b01, cwf(2'b01, 5'd3, 5'd1, 5'd2, 5'b01000, F_RTYPE), '0, 1'b0, 1'b0);
        step(32'h8B020023, 1'b0);
        step(32'h8B020023, 1'b0);

        check_eq("sb_empty", 64'(scoreboard.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
